rsa_modexp_engine: RTL and testbench
====================================

RSA_MODEXP_ENGINE -- requirements
Module: rsa_modexp_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/modulus width in bits (>= 4).
REQ-002 SHALL have parameter EXP_WIDTH, default 32: exponent width in bits (>= 1).
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  engine accepts request.
REQ-007 SHALL have port in_data  input  WIDTH  message/ciphertext.
REQ-008 SHALL have port mode  input  1  0 = encrypt (use exp_e), 1 = decrypt (use exp_d).
REQ-009 SHALL have ports exp_e, exp_d  input  EXP_WIDTH  public/private exponents.
REQ-010 SHALL have port modulus  input  WIDTH  RSA modulus n.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_data  output  WIDTH  in_data^exp mod n.
REQ-014 SHALL have port out_err  output  1  operand error, qualified by out_valid.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, SQR, MUL, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready on a rising edge -> LOAD.
REQ-018 On accept SHALL capture in_data, modulus and exp_e or exp_d per mode; later input changes are ignored until the next accept.
REQ-019 LOAD SHALL check operands: modulus < 2 or in_data >= modulus -> DONE with out_err=1, out_data=0; otherwise result register=1, bit index=EXP_WIDTH-1, -> SQR.
REQ-020 Modular multiply SHALL be interleaved shift-add: 1 setup cycle plus WIDTH iterations MSB-first (acc = 2*acc mod n; if multiplier bit set, acc = acc + a mod n), i.e. exactly WIDTH+1 cycles.
REQ-021 Internal accumulator SHALL be WIDTH+2 bits; each iteration SHALL reduce by conditional subtraction so acc < n always holds; no truncation of intermediate sums.
REQ-022 SQR SHALL compute r = r*r mod n, then -> MUL.
REQ-023 MUL SHALL compute t = r*m mod n always (constant time); r takes t only if the current exponent bit is 1, otherwise r is unchanged.
REQ-024 After MUL: bit index > 0 -> decrement, -> SQR; bit index = 0 -> DONE.
REQ-025 Latency SHALL be data-independent: for a valid request out_valid rises exactly 1 + 2*EXP_WIDTH*(WIDTH+1) rising edges after the accepting edge; error path: exactly 2 edges.
REQ-026 In DONE, out_valid=1, out_data/out_err SHALL hold stable until out_valid & out_ready, then -> IDLE next edge; no new accept in the same cycle.
REQ-027 Exponent 0 SHALL yield out_data=1 (given valid operands); in_data=0 SHALL yield 0 for nonzero exponent.
REQ-028 out_data and out_err SHALL be 0 whenever out_valid=0.

Reset
REQ-029 reset SHALL asynchronously force IDLE and clear all registers; outputs after reset: in_ready=1, out_valid=0, out_data=0, out_err=0, busy=0.
REQ-030 reset asserted mid-operation SHALL abort the computation; no stale result SHALL appear after release.
REQ-031 First accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-032 WIDTH=32, EXP_WIDTH=32, n=3233, e=17, mode=0, in_data=65 -> out_data=2790, out_err=0, out_valid after exactly 2113 edges.
REQ-033 Same key, d=2753, mode=1, in_data=2790 -> out_data=65; latency identical to REQ-032 despite different exponent.
REQ-034 exp_e=0, in_data=123, n=3233 -> out_data=1; in_data=0, e=17 -> out_data=0.
REQ-035 modulus=1 or in_data=3233 with n=3233 -> out_err=1, out_data=0, out_valid 2 edges after accept.
REQ-036 out_ready held low 50 cycles after out_valid -> out_data stable, in_ready=0, busy=1; out_ready=1 -> IDLE next edge.
REQ-037 reset pulsed during SQR of a request -> all outputs at reset values; next request (65, e=17) returns 2790.

Source files
------------

// File: rtl/rsa_modexp_engine.sv
// Constant-time modular exponentiation engine. It uses left-to-right square-and-multiply
// built on an interleaved shift-add modular multiplier that takes WIDTH+1 cycles.
module rsa_modexp_engine #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 mode,
  input  logic [EXP_WIDTH-1:0] exp_e,
  input  logic [EXP_WIDTH-1:0] exp_d,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]     m_q, n_q, r_q, b_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [WIDTH+1:0]     acc_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic                 err_q;

  logic                 bad, last;
  logic [WIDTH-1:0]     mult;
  logic [WIDTH+1:0]     a_ext, n_ext, dbl, dbl_red, sum, sum_red;

  assign bad  = (n_q < WIDTH'(2)) || (m_q >= n_q);
  assign last = (cnt_q == CW'(WIDTH));
  assign mult = (state == SQR) ? r_q : m_q;

  // One multiplier iteration: acc stays below n after each conditional subtraction.
  always_comb begin
    a_ext   = {2'b00, r_q};
    n_ext   = {2'b00, n_q};
    dbl     = {acc_q[WIDTH:0], 1'b0};
    dbl_red = (dbl >= n_ext) ? dbl - n_ext : dbl;
    sum     = dbl_red + (b_q[WIDTH-1] ? a_ext : '0);
    sum_red = (sum >= n_ext) ? sum - n_ext : sum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Error path lingers one extra LOAD cycle so it reports two edges after accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = LOAD;
      LOAD: begin
        if (!bad)      state_nxt = SQR;
        else if (err_q) state_nxt = DONE;
      end
      SQR:  if (last) state_nxt = MUL;
      MUL:  if (last) state_nxt = (bit_q == '0) ? DONE : SQR;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q   <= '0;
      n_q   <= '0;
      r_q   <= '0;
      b_q   <= '0;
      exp_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      bit_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          m_q   <= in_data;
          n_q   <= modulus;
          exp_q <= mode ? exp_d : exp_e;
          r_q   <= '0;
          err_q <= 1'b0;
        end
        LOAD: begin
          if (bad) err_q <= 1'b1;
          else begin
            r_q   <= WIDTH'(1);
            bit_q <= BW'(EXP_WIDTH - 1);
            cnt_q <= '0;
          end
        end
        SQR, MUL: begin
          if (cnt_q == '0) begin
            acc_q <= '0;
            b_q   <= mult;
          end else begin
            acc_q <= sum_red;
            b_q   <= b_q << 1;
          end
          cnt_q <= last ? '0 : cnt_q + CW'(1);
          if (last && state == SQR) r_q <= sum_red[WIDTH-1:0];
          // The product is always formed; only the exponent bit decides whether it is kept.
          if (last && state == MUL) begin
            if (exp_q[EXP_WIDTH-1]) r_q <= sum_red[WIDTH-1:0];
            exp_q <= exp_q << 1;
            if (bit_q != '0) bit_q <= bit_q - BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_err   = out_valid & err_q;
  assign out_data  = (out_valid && !err_q) ? r_q : '0;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Bench for rsa_modexp_engine: a table of known RSA vectors, random requests checked
// against an arithmetic square-and-multiply model, and handshake/reset sequences.
module tb_rsa_modexp_engine;
  localparam int W = 32;
  localparam int E = 32;
  localparam int LAT_OK  = 1 + 2 * E * (W + 1);
  localparam int LAT_ERR = 2;

  logic          clk = 0, reset = 1;
  logic          in_valid = 0, in_ready, mode = 0;
  logic [W-1:0]  in_data = '0, modulus = '0, out_data;
  logic [E-1:0]  exp_e = '0, exp_d = '0;
  logic          out_valid, out_ready = 0, out_err, busy;

  int checks = 0, failures = 0;

  rsa_modexp_engine #(.WIDTH(W), .EXP_WIDTH(E)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .exp_e(exp_e), .exp_d(exp_d),
    .modulus(modulus), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         md;
    logic [E-1:0] e, d;
    logic [W-1:0] n;
    logic [W-1:0] exp_data;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_modexp(logic [W-1:0] b, logic [E-1:0] e, logic [W-1:0] n);
    logic [63:0] r, base;
    r    = 64'd1 % 64'(n);
    base = 64'(b) % 64'(n);
    for (int i = E - 1; i >= 0; i--) begin
      r = (r * r) % 64'(n);
      if (e[i]) r = (r * base) % 64'(n);
    end
    return r[W-1:0];
  endfunction

  // Issues one request and waits for out_valid; inputs are scrambled after accept.
  task automatic run_req(input logic [W-1:0] d, input logic md, input logic [E-1:0] ee,
                         input logic [E-1:0] dd, input logic [W-1:0] n,
                         output logic [W-1:0] odata, output logic oerr, output int lat);
    logic leak;
    leak = 0;
    @(negedge clk);
    in_data = d; mode = md; exp_e = ee; exp_d = dd; modulus = n; in_valid = 1;
    chk("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0; in_data = $urandom; exp_e = $urandom; exp_d = $urandom;
    modulus = $urandom; mode = ~md;
    lat = 0;
    while (!out_valid && lat < LAT_OK + 50) begin
      if (out_data !== '0 || out_err !== 1'b0) leak = 1;
      @(posedge clk); #1;
      lat++;
    end
    chk("outputs_zero_while_busy", leak, 0);
    odata = out_data;
    oerr  = out_err;
  endtask

  task automatic release_out();
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    chk("idle_after_release", in_ready, 1);
  endtask

  vec_t vecs[6];
  logic [W-1:0] od, saved, rn, rd;
  logic [E-1:0] re, rdd;
  logic rm, oe, unstable;
  int lat;

  initial begin
    vecs[0] = '{65,   0, 17, 2753, 3233, 2790, 0, LAT_OK};
    vecs[1] = '{2790, 1, 17, 2753, 3233, 65,   0, LAT_OK};
    vecs[2] = '{123,  0, 0,  2753, 3233, 1,    0, LAT_OK};
    vecs[3] = '{0,    0, 17, 2753, 3233, 0,    0, LAT_OK};
    vecs[4] = '{3232, 0, 17, 2753, 3233, 3232, 0, LAT_OK};
    vecs[5] = '{5,    0, 17, 2753, 1,    0,    1, LAT_ERR};

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); reset = 0;

    foreach (vecs[i]) begin
      run_req(vecs[i].data, vecs[i].md, vecs[i].e, vecs[i].d, vecs[i].n, od, oe, lat);
      chk($sformatf("vec%0d_data", i), od, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), oe, vecs[i].exp_err);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      release_out();
    end

    // in_data equal to modulus is out of range
    run_req(3233, 0, 17, 0, 3233, od, oe, lat);
    chk("data_eq_n_err", oe, 1);
    chk("data_eq_n_data", od, 0);
    chk("data_eq_n_lat", lat, LAT_ERR);
    release_out();

    for (int k = 0; k < 8; k++) begin
      rn = (k < 4) ? W'($urandom_range(2, 5000)) : W'($urandom);
      if (rn < 2) rn = 3;
      rd = W'($urandom) % rn;
      re = $urandom; rdd = $urandom; rm = 1'($urandom);
      run_req(rd, rm, re, rdd, rn, od, oe, lat);
      chk($sformatf("rand%0d_data", k), od, ref_modexp(rd, rm ? rdd : re, rn));
      chk($sformatf("rand%0d_err", k), oe, 0);
      chk($sformatf("rand%0d_lat", k), lat, LAT_OK);
      release_out();
    end

    // Backpressure: result must hold while out_ready is low, and no accept while DONE
    run_req(65, 0, 17, 0, 3233, od, oe, lat);
    saved = out_data;
    unstable = 0;
    @(negedge clk); in_valid = 1; in_data = 7; modulus = 3233;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (out_data !== saved || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
        unstable = 1;
    end
    chk("hold_stable", unstable, 0);
    chk("hold_data", saved, 2790);
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("hold_rel_in_ready", in_ready, 1);
    chk("hold_rel_busy", busy, 0);
    chk("hold_rel_out_valid", out_valid, 0);
    in_valid = 0;

    // Reset in the middle of a squaring step
    @(negedge clk);
    in_data = 65; exp_e = 17; mode = 0; modulus = 3233; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    repeat (10) @(posedge clk);
    #2 reset = 1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_err", out_err, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk); reset = 0;
    run_req(65, 0, 17, 0, 3233, od, oe, lat);
    chk("post_rst_data", od, 2790);
    chk("post_rst_lat", lat, LAT_OK);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
